// File: rtl/cordic_rot_sched.sv
// Round-robin scheduler sharing one fixed-latency CORDIC rotator among NREQ requesters.
// Tags ride a valid pipe beside the rotator; results land in a FWFT FIFO guarded by credits.
module cordic_rot_sched #(
    parameter int NREQ       = 4,
    parameter int LAT        = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int THETA_MAX  = 9944,
    localparam int TAGW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    input  logic [16*NREQ-1:0]   req_theta,
    output logic [15:0]          rot_x0,
    output logic [15:0]          rot_y0,
    output logic [15:0]          rot_theta,
    input  logic [15:0]          rot_xf,
    input  logic [15:0]          rot_yf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_x,
    output logic [15:0]          res_y,
    output logic [TAGW-1:0]      res_tag,
    output logic                 res_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 33 + TAGW;

    logic [TAGW-1:0] ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight;
    logic            issue_ok;
    logic            grant_found;
    logic [TAGW-1:0] grant_idx;
    logic [TAGW-1:0] cand;
    logic [15:0]     sel_x;
    logic [15:0]     sel_y;
    logic [15:0]     sel_theta;

    logic [LAT:0]    pipe_v;
    logic [LAT:0]    pipe_err;
    logic [TAGW-1:0] pipe_tag [0:LAT];

    logic [EW-1:0]   mem [0:FIFO_DEPTH-1];
    logic [EW-1:0]   head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Credits cover both stored and in-flight results, so the FIFO can never be overrun.
    assign issue_ok = !rst &&
                      (({1'b0, fifo_count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (issue_ok) begin
            for (int off = 1; off <= NREQ; off++) begin
                cand = TAGW'((int'(ptr) + off) % NREQ);
                if (!grant_found && req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_x     = req_x[16*grant_idx +: 16];
    assign sel_y     = req_y[16*grant_idx +: 16];
    assign sel_theta = req_theta[16*grant_idx +: 16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_x0    <= '0;
            rot_y0    <= '0;
            rot_theta <= '0;
            ptr       <= TAGW'(NREQ - 1);
            inflight  <= '0;
        end else begin
            if (grant_found) begin
                rot_x0    <= sel_x;
                rot_y0    <= sel_y;
                rot_theta <= sel_theta;
                ptr       <= grant_idx;
            end
            inflight <= inflight + CW'(grant_found) - CW'(pipe_v[LAT]);
        end
    end

    // The rotator never stalls, so the tag pipe shifts every clock to stay aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v   <= '0;
            pipe_err <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= grant_found;
            pipe_err[0] <= grant_found && (sel_theta > 16'(THETA_MAX));
            pipe_tag[0] <= grant_idx;
            for (int i = 1; i <= LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign push = pipe_v[LAT];
    assign pop  = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {rot_xf, rot_yf, pipe_tag[LAT], pipe_err[LAT]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // Outputs are forced to zero while empty so reset and idle states look clean.
    assign head      = mem[rd_ptr];
    assign res_valid = (fifo_count != '0);
    assign res_x     = res_valid ? head[EW-1 -: 16]     : '0;
    assign res_y     = res_valid ? head[EW-17 -: 16]    : '0;
    assign res_tag   = res_valid ? head[TAGW:1]         : '0;
    assign res_err   = res_valid ? head[0]              : 1'b0;

endmodule

// File: doc/cordic_rot_sched.md
Name: cordic_rot_sched

Overview:
- Shares one 8-stage pipelined CORDIC rotator among NREQ requesters.
- Round-robin arbitration accepts one rotation request per cycle and registers its operands onto the rotator inputs.
- Tracks each request's tag alongside the fixed-latency rotator pipeline, which has no valid and no stall.
- Buffers results in a FIFO with a valid/ready output; credit accounting guarantees no result is ever dropped.

Parameters:
- NREQ, 4, number of requesters (2..8); TAGW = clog2(NREQ), min 1.
- LAT, 8, rotator latency in clocks from its input sample to xf/yf.
- FIFO_DEPTH, 16, result FIFO entries (power of 2, >= LAT+1).
- THETA_MAX, 9944, largest convergent angle in 0.01-degree units; this is the sum of the stage angles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, at most one bit high.
- req_x  in  16*NREQ  x0 operands; requester i occupies bits [16i+15:16i].
- req_y  in  16*NREQ  y0 operands, same packing.
- req_theta  in  16*NREQ  target angles, unsigned, 0.01-degree units.
- rot_x0  out  16  registered rotator x input.
- rot_y0  out  16  registered rotator y input.
- rot_theta  out  16  registered rotator angle input.
- rot_xf  in  16  rotator x result.
- rot_yf  in  16  rotator y result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_x  out  16  result x, unscaled (CORDIC gain not removed).
- res_y  out  16  result y, unscaled.
- res_tag  out  TAGW  index of the originating requester.
- res_err  out  1  theta exceeded THETA_MAX; result not meaningful.

Behaviour:
- Reset values: req_ready=0, res_valid=0; rot_x0/rot_y0/rot_theta=0; res_x/res_y/res_tag/res_err=0.
- Reset clears the RR pointer to NREQ-1, so requester 0 has first priority.
- Reset empties the FIFO, clears the valid/tag pipe and sets inflight=0.
- Credit rule: issue_ok = (fifo_count + inflight) < FIFO_DEPTH.
  - Both terms are the registered values, so a same-cycle FIFO pop does not add credit until the next cycle.
- Arbitration:
  - When issue_ok, grant the first asserted req_valid searching from ptr+1 upward with wrap.
  - req_ready[g]=1 for the granted index only; req_ready is combinational from req_valid and state.
  - Requesters must not make req_valid depend on req_ready.
  - Handshake = req_valid[i] & req_ready[i]. On the handshake edge: operands are loaded into the rot_* registers, ptr<=g, inflight+1.
  - A new pipe entry {1, tag=g, err=(theta>THETA_MAX)} is loaded at the same edge.
  - With no handshake, the rot_* registers hold their value and a zero-valid entry is loaded.
- Valid/tag pipe:
  - LAT+1 stages, shifting every clock unconditionally; the rotator never stalls.
  - An entry loaded at edge k reaches stage LAT at edge k+LAT, aligned with the rotator's rot_xf/rot_yf for those operands.
  - When stage LAT is valid, the next edge writes {rot_xf, rot_yf, tag, err} into the FIFO and decrements inflight.
- Result latency: handshake edge k to res_valid high after edge k+LAT+1, i.e. 9 clocks for LAT=8, when the FIFO was empty.
- Throughput: 1 request/clock sustained while res_ready=1.
- FIFO:
  - First-word-fall-through; res_* show the head entry while res_valid=1.
  - Pop on res_valid & res_ready.
  - Simultaneous push and pop leaves fifo_count unchanged and both take effect.
  - Overflow cannot occur by construction; verification asserts fifo_count+inflight <= FIFO_DEPTH.
- Out-of-range angles are still issued, keeping order and latency uniform, and are marked via res_err.
  - Any theta >= 16'h8000 (negative in two's complement) is out of range because the rotator compares unsigned.
- Ordering: results return in issue order. Per-requester order is preserved.
- Reset mid-operation: all in-flight results are discarded. Stale rotator outputs are ignored because the pipe valids are cleared; the rotator itself has no reset.
- The first post-reset handshake is allowed one cycle after rst deasserts.

Test Plan:
- Single request: req0 x=1000, y=0, theta=3000, res_ready=1 -> res_valid 9 clocks after the handshake, res_tag=0, res_err=0, res_x/res_y match the rotator golden model.
- All four requesters held valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, one per cycle; results return in the same tag order.
- res_ready=0 with continuous requests -> exactly FIFO_DEPTH=16 handshakes, then req_ready=0. After one pop, exactly one new grant occurs, delayed one cycle.
- theta=9945 and theta=16'hF000 -> both accepted with res_err=1; theta=9944 -> res_err=0.
- Assert rst for 1 cycle with 5 requests in flight and 3 results stored -> res_valid=0 immediately. No stale results appear within 2*LAT cycles; the next request after reset returns tag and data correctly.
- Simultaneous pop and push every cycle at full rate for 100 requests -> fifo_count stays constant, no loss or duplication, and tags match the issue sequence.
